// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

  localparam int DW_DEF       = 32;
  localparam int AW_DEF       = 5;
  localparam int MAX_WAIT_DEF = 4;
  localparam int CW_DEF       = 3;
  localparam int REG_ZERO     = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bits for outstanding MDU results, with two decode query ports.
module regfile_scoreboard
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set_valid,
  input  logic [AW-1:0] i_set_reg,
  input  logic          i_clr_valid,
  input  logic [AW-1:0] i_clr_reg,
  input  logic [AW-1:0] i_q_a,
  input  logic [AW-1:0] i_q_b,
  output logic          o_busy_a,
  output logic          o_busy_b
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  always_comb begin
    // NOTE: every always_comb output gets a default before any condition, otherwise a latch is inferred.
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_valid && (i_set_reg != AW'(REG_ZERO))) w_set_mask[i_set_reg] = 1'b1;
    if (i_clr_valid) w_clr_mask[i_clr_reg] = 1'b1;
  end

  // Clear first, then set, so a new issue to the register being retired stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the pending vector is plain flops, not a RAM, so it is reset; stale bits would stall decode forever.
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
  end

  assign o_busy_a = (i_q_a != AW'(REG_ZERO)) && r_pend[i_q_a];
  assign o_busy_b = (i_q_b != AW'(REG_ZERO)) && r_pend[i_q_b];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-writer arbiter for the register-file write port: WB stage has priority,
// MDU is force-granted after MAX_WAIT refusals; also tracks pending MDU writes.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          md_valid,
  input  logic [AW-1:0] md_reg,
  input  logic [DW-1:0] md_data,
  output logic          md_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_reg,
  input  logic [AW-1:0] q_rs,
  input  logic [AW-1:0] q_rt,
  output logic          busy_rs,
  output logic          busy_rt,
  output logic          stall_wb,
  output logic          rf_we,
  output logic [AW-1:0] rf_reg,
  output logic [DW-1:0] rf_data
);

  logic [CW-1:0] r_cnt;
  logic          r_rf_we;
  logic [AW-1:0] r_rf_reg;
  logic [DW-1:0] r_rf_data;

  logic          w_starve;
  logic          w_fire0;
  logic          w_fire1;
  gnt_e          w_gnt;
  logic [AW-1:0] w_sel_reg;
  logic [DW-1:0] w_sel_data;

  assign w_starve = (r_cnt == CW'(MAX_WAIT));
  assign wb_ready = !w_starve;
  assign md_ready = w_starve || !wb_valid;
  assign w_fire0  = wb_valid && wb_ready;
  assign w_fire1  = md_valid && md_ready;
  assign stall_wb = wb_valid && !wb_ready;

  always_comb begin
    w_gnt      = GNT_NONE;
    w_sel_reg  = r_rf_reg;
    w_sel_data = r_rf_data;
    if (w_fire0) begin
      w_gnt      = GNT_WB;
      w_sel_reg  = wb_reg;
      w_sel_data = wb_data;
    end else if (w_fire1) begin
      w_gnt      = GNT_MD;
      w_sel_reg  = md_reg;
      w_sel_data = md_data;
    end
  end

  // Refusals only accumulate while port 1 is waiting; saturation is implicit
  // because a starved port 1 is always granted.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)                     r_cnt <= '0;
    else if (!md_valid || w_fire1)  r_cnt <= '0;
    else if (!w_starve)             r_cnt <= r_cnt + 1'b1;
  end

  // The register file writes on negedge, so a registered write is visible in its own cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we   <= 1'b0;
      r_rf_reg  <= '0;
      r_rf_data <= '0;
    end else begin
      r_rf_we <= (w_gnt != GNT_NONE) && (w_sel_reg != AW'(REG_ZERO));
      if (w_gnt != GNT_NONE) begin
        r_rf_reg  <= w_sel_reg;
        r_rf_data <= w_sel_data;
      end
    end
  end

  assign rf_we   = r_rf_we;
  assign rf_reg  = r_rf_reg;
  assign rf_data = r_rf_data;

  regfile_scoreboard #(
    .AW (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set_valid (iss_valid),
    .i_set_reg   (iss_reg),
    .i_clr_valid (w_fire1),
    .i_clr_reg   (md_reg),
    .i_q_a       (q_rs),
    .i_q_b       (q_rt),
    .o_busy_a    (busy_rs),
    .o_busy_b    (busy_rt)
  );

endmodule
